regfile_dump_ctrl: RTL and testbench

//  Debug read-side initiator for the 32x32 register file.
//  On a start pulse it walks the register file read port over an address range
//  [first_addr..last_addr]. It emits each word on a valid/ready stream tagged

---
 rtl/regfile_pkg.sv | 27 ++
 rtl/regfile_dump_ctrl.sv | 102 ++++++++++
 tb/tb_regfile_dump_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg : shared register-file geometry and dump FSM state encoding
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_FETCH = ST_FETCH,
    S_WAIT  = ST_WAIT,
    S_DONE  = ST_DONE
  } dump_state_t;

endpackage

`default_nettype wire

// File: rtl/regfile_dump_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_dump_ctrl : walks a register-file address range and streams each
// word out on a valid/ready interface, tagged with its address.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile_dump_ctrl
  import regfile_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  dump_state_t       state;
  dump_state_t       state_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] end_addr;
  logic              handshake;

  assign handshake = out_valid && out_ready;
  assign rd_addr   = cur_addr;
  assign busy      = (state == S_FETCH) || (state == S_WAIT);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_WAIT;
      S_WAIT:  if (handshake) state_nxt = out_last ? S_DONE : S_FETCH;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // abort outranks everything, including a same-cycle start
    if (abort) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cur_addr  <= '0;
      end_addr  <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (abort) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            cur_addr <= first_addr;
            end_addr <= last_addr;
          end
        end
        S_FETCH: begin
          // rd_data is combinational off cur_addr, so it is captured here
          out_data  <= rd_data;
          out_addr  <= cur_addr;
          out_last  <= (cur_addr == end_addr);
          out_valid <= 1'b1;
        end
        S_WAIT: begin
          if (handshake) begin
            out_valid <= 1'b0;
            if (!out_last) cur_addr <= cur_addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_dump_ctrl.sv
// Self-checking bench for regfile_dump_ctrl: a behavioural register file plus
// an expected-word queue built from the address-range rules.
`default_nettype none

module tb_regfile_dump_ctrl;

  logic        clk = 1'b0;
  logic        rstb;
  logic        start;
  logic [4:0]  first_addr;
  logic [4:0]  last_addr;
  logic        abort;
  logic        busy;
  logic        done;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic        out_last;

  logic [31:0] mem [32];
  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign rd_data = mem[rd_addr];

  regfile_dump_ctrl dut (
    .clk        (clk),
    .rstb       (rstb),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .out_last   (out_last)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One dump from start to done/abort. abort_word >= 0 aborts during that
  // word's WAIT; poke5 overwrites reg 5 as its FETCH cycle ends; restart_mid
  // pulses start while busy.
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int stall_pct,
                          input int abort_word, input bit poke5, input bit restart_mid);
    logic [4:0]  ea[$];
    logic [31:0] ed[$];
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        pl;
    int n, got, t, t_first, t_last;
    bit pv_stall, aborted, wpend;
    n = ((int'(l) - int'(f)) & 31) + 1;
    for (int i = 0; i < n; i++) begin
      ea.push_back(5'((int'(f) + i) % 32));
      ed.push_back(mem[(int'(f) + i) % 32]);
    end
    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    step();
    start = 1'b0;
    t = 1; got = 0; t_first = -1; t_last = -1;
    pv_stall = 0; aborted = 0; wpend = 0;
    pa = '0; pd = '0; pl = 1'b0;
    while (got < n && !aborted && t < 3000) begin
      chk("busy_during", busy, 1);
      chk("done_early", done, 0);
      if (pv_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_addr", out_addr, pa);
        chk("stall_data", out_data, pd);
        chk("stall_last", out_last, pl);
      end
      out_ready = ($urandom_range(99) >= stall_pct);
      if (poke5 && busy && !out_valid && rd_addr == 5'd5) wpend = 1;
      if (out_valid) begin
        if (t_first < 0) t_first = t;
        if (abort_word >= 0 && got == abort_word) begin
          out_ready = 1'b0;
          abort     = 1'b1;
          aborted   = 1;
        end
        if (out_ready) begin
          chk("word_addr", out_addr, ea[got]);
          chk("word_data", out_data, ed[got]);
          chk("word_last", out_last, (got == n - 1));
          got++;
          t_last = t;
        end
        pv_stall = !out_ready;
        pa = out_addr; pd = out_data; pl = out_last;
      end else begin
        pv_stall = 0;
      end
      if (restart_mid && t == 5) begin
        start = 1'b1; first_addr = 5'd20; last_addr = 5'd25;
      end
      step();
      t++;
      start = 1'b0;
      abort = 1'b0;
      if (wpend) begin
        mem[5] = 32'hDEADBEEF;
        wpend  = 0;
      end
    end
    out_ready = 1'b1;
    if (aborted) begin
      chk("abort_valid", out_valid, 0);
      chk("abort_last", out_last, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      step();
      chk("abort_nodone", done, 0);
    end else begin
      chk("word_count", got, n);
      chk("done_pulse", done, 1);
      chk("done_busy", busy, 0);
      step();
      chk("done_clear", done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_valid", out_valid, 0);
      if (stall_pct == 0) begin
        chk("first_latency", t_first, 2);
        chk("last_hs_cycle", t_last, 2 * n);
      end
    end
  endtask

  initial begin
    rstb = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    first_addr = '0; last_addr = '0;
    for (int i = 0; i < 32; i++) mem[i] = i * 32'h11111111;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rstb = 1'b1;
    step();

    run_dump(5'd0, 5'd31, 0, -1, 0, 0);
    run_dump(5'd3, 5'd3, 0, -1, 0, 0);
    run_dump(5'd30, 5'd1, 0, -1, 0, 0);
    run_dump(5'd0, 5'd7, 40, -1, 0, 0);

    run_dump(5'd0, 5'd7, 0, 2, 0, 0);
    step();
    run_dump(5'd0, 5'd3, 0, -1, 0, 0);

    run_dump(5'd2, 5'd9, 30, -1, 1, 1);
    chk("reg5_written", mem[5], 32'hDEADBEEF);
    run_dump(5'd5, 5'd5, 0, -1, 0, 0);

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 32; i++) mem[i] = $urandom;
      run_dump(5'($urandom_range(31)), 5'($urandom_range(31)), $urandom_range(60), -1, 0, 0);
    end

    // asynchronous reset in the middle of a dump
    first_addr = 5'd0; last_addr = 5'd31; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    chk("pre_rst_busy", busy, 1);
    rstb = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_rd_addr", rd_addr, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_out_addr", out_addr, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_last", out_last, 0);
    @(negedge clk) rstb = 1'b1;
    step();
    chk("post_rst_done", done, 0);
    run_dump(5'd10, 5'd12, 20, -1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
